// File: rtl/round_sched_ctrl.sv
// Per-round sequencer: collects HB/CH packets, publishes energy/hop/CH summary
// with a one-cycle en_MNI strobe, then waits for this node's TDMA slot and grants the radio.
module round_sched_ctrl #(
  parameter logic [15:0] HB_WINDOW = 16'd1000,
  parameter logic [15:0] SLOT_LEN  = 16'd64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start_round,
  input  logic        abort,
  input  logic        pkt_valid,
  input  logic [1:0]  pkt_type,
  input  logic [15:0] pkt_src,
  input  logic [15:0] pkt_hops,
  input  logic [15:0] pkt_energy,
  input  logic [15:0] my_timeslot,
  input  logic        tx_done,
  output logic        en_MNI,
  output logic [15:0] e_max,
  output logic [15:0] e_min,
  output logic [15:0] hops,
  output logic [15:0] ch_ID,
  output logic        tx_grant,
  output logic        busy,
  output logic        round_done
);
  typedef enum logic [2:0] {IDLE, COLLECT, UPDATE, SLOT_WAIT, TX, DONE} state_t;

  state_t      state, nxt;
  logic [31:0] cnt, wait_len, prod;
  logic [15:0] hmin, emax_a, emin_a, ch_best, ch_id_a;
  logic        hb_seen, ch_seen;

  logic        hb, chp, take;
  logic [15:0] n_hmin, n_emax, n_emin;
  logic        n_hb;

  assign prod = {16'd0, my_timeslot} * {16'd0, SLOT_LEN};

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start_round) nxt = COLLECT;
      COLLECT:   if (cnt == {16'd0, HB_WINDOW} - 32'd1) nxt = UPDATE;
      UPDATE:    nxt = (my_timeslot == 16'd0) ? TX : SLOT_WAIT;
      SLOT_WAIT: if (cnt == wait_len - 32'd1) nxt = TX;
      TX:        if (tx_done || cnt == {16'd0, SLOT_LEN} - 32'd1) nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // Next accumulator values include the current cycle's packet, so the
  // packet on the last COLLECT cycle reaches the outputs loaded on UPDATE entry.
  always_comb begin
    hb     = (state == COLLECT) && pkt_valid && (pkt_type == 2'd0);
    chp    = (state == COLLECT) && pkt_valid && (pkt_type == 2'd1);
    take   = chp && (!ch_seen || pkt_energy > ch_best);
    n_hmin = (hb && pkt_hops < hmin)     ? pkt_hops   : hmin;
    n_emax = (hb && pkt_energy > emax_a) ? pkt_energy : emax_a;
    n_emin = (hb && pkt_energy < emin_a) ? pkt_energy : emin_a;
    n_hb   = hb_seen | hb;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      wait_len   <= 32'd0;
      hmin       <= 16'hFFFF;
      emax_a     <= 16'd0;
      emin_a     <= 16'hFFFF;
      hb_seen    <= 1'b0;
      ch_seen    <= 1'b0;
      ch_best    <= 16'd0;
      ch_id_a    <= 16'hFFFF;
      en_MNI     <= 1'b0;
      e_max      <= 16'd0;
      e_min      <= 16'd0;
      hops       <= 16'hFFFF;
      ch_ID      <= 16'hFFFF;
      tx_grant   <= 1'b0;
      busy       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= (nxt != state) ? 32'd0 : cnt + 32'd1;
      en_MNI     <= (state == COLLECT) && (nxt == UPDATE);
      tx_grant   <= (nxt == TX);
      round_done <= (nxt == DONE);
      busy       <= (nxt != IDLE);
      if (state == UPDATE) wait_len <= prod;
      if (state == IDLE && nxt == COLLECT) begin
        hmin    <= 16'hFFFF;
        emax_a  <= 16'd0;
        emin_a  <= 16'hFFFF;
        hb_seen <= 1'b0;
        ch_seen <= 1'b0;
        ch_best <= 16'd0;
        ch_id_a <= 16'hFFFF;
      end else if (state == COLLECT) begin
        hmin    <= n_hmin;
        emax_a  <= n_emax;
        emin_a  <= n_emin;
        hb_seen <= n_hb;
        if (take) begin
          ch_seen <= 1'b1;
          ch_best <= pkt_energy;
          ch_id_a <= pkt_src;
        end
      end
      if (state == COLLECT && nxt == UPDATE) begin
        e_max <= n_hb ? n_emax : 16'd0;
        e_min <= n_hb ? n_emin : 16'd0;
        hops  <= (n_hmin == 16'hFFFF) ? 16'hFFFF : n_hmin + 16'd1;
        ch_ID <= take ? pkt_src : ch_id_a;
      end
    end
  end
endmodule
